jtframe_vid_capture: RTL and testbench

JTFRAME_VID_CAPTURE -- requirements
Module: jtframe_vid_capture

---
 rtl/jtframe_vid_pkg.sv | 33 +++
 rtl/jtframe_vid_capture_if.sv | 11 +
 rtl/jtframe_vid_fifo.sv | 59 +++++
 rtl/jtframe_vid_capture.sv | 157 +++++++++++++++
 tb/tb_jtframe_vid_capture.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/jtframe_vid_pkg.sv
// rtl/jtframe_vid_pkg.sv - shared types, CRC constants and helpers for the video capture block
package jtframe_vid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } vid_state_e;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    function automatic int rec_width(input int cw);
        return 3 * cw + 2;
    endfunction

    // Advances the CRC over the low nbits of data, most significant bit first
    function automatic logic [15:0] crc16_step(input logic [15:0] crc_in,
                                               input logic [23:0] data,
                                               input int          nbits);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 23; i >= 0; i--) begin
            if (i < nbits) begin
                fb = c[15] ^ data[i];
                c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/jtframe_vid_capture_if.sv
// rtl/jtframe_vid_capture_if.sv - captured-record output stream
interface jtframe_vid_capture_if #(
    parameter int W = 14
) ();
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;

    modport master (output dout, output dout_valid, input  dout_ready);
    modport slave  (input  dout, input  dout_valid, output dout_ready);
endinterface

// File: rtl/jtframe_vid_fifo.sv
// rtl/jtframe_vid_fifo.sv - first-word-fall-through record FIFO, drops writes when full
module jtframe_vid_fifo #(
    parameter int W     = 14,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_i,
    input  logic [W-1:0] din_i,
    input  logic         rd_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic         full_o,
    output logic         drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q,  cnt_d;
    logic          rd_ok, wr_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign rd_ok   = rd_i && !empty_o;
    // A read in the same cycle frees the slot, so a full FIFO still takes the write
    assign wr_ok   = wr_i && (!full_o || rd_ok);
    assign drop_o  = wr_i && !wr_ok;
    assign dout_o  = empty_o ? '0 : mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (wr_ok) wptr_d = wptr_q + 1'b1;
        if (rd_ok) rptr_d = rptr_q + 1'b1;
        if (wr_ok && !rd_ok) cnt_d = cnt_q + 1'b1;
        else if (!wr_ok && rd_ok) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/jtframe_vid_capture.sv
// rtl/jtframe_vid_capture.sv - video frame capture into a stream FIFO; JTFRAME_VIDCRC_EN adds per-frame CRC-16
module jtframe_vid_capture
    import jtframe_vid_pkg::*;
#(
    parameter int CW     = 4,
    parameter int DEPTH  = 16,
    parameter int START  = 0,
    parameter int FRAMES = 0
) (
    input  logic                  pxl_clk,
    input  logic                  rst_base,
    input  logic                  pxl_cen,
    input  logic                  hs,
    input  logic                  vs,
    input  logic [CW-1:0]         red,
    input  logic [CW-1:0]         green,
    input  logic [CW-1:0]         blue,
    input  logic                  downloading,
    output logic [31:0]           frame_cnt,
    jtframe_vid_capture_if.master vid,
    output logic                  capturing,
    output logic                  done,
    output logic                  overflow,
    output logic [15:0]           crc,
    output logic                  crc_valid
);
    localparam int          RW       = rec_width(CW);
    localparam logic [31:0] START_U  = START;
    localparam logic [31:0] FRAMES_U = FRAMES;

    vid_state_e  state_q;
    logic        vs_q;
    logic [31:0] frame_cnt_q;
    logic [31:0] cap_frames_q;
    logic        capturing_q, done_q, overflow_q;

    logic        vs_rise, cap_start, frame_end;
    logic [31:0] frame_inc;
    logic        fifo_wr, fifo_empty, fifo_full, fifo_drop;
    logic [RW-1:0] fifo_din, fifo_dout;

    assign vs_rise   = vs && !vs_q;
    assign frame_inc = frame_cnt_q + 32'd1;
    assign cap_start = (state_q == ST_IDLE) && vs_rise && (frame_inc >= START_U) && !downloading;
    // Leaving on a download takes priority over closing the frame
    assign frame_end = (state_q == ST_CAPTURE) && vs_rise && !downloading;

    assign fifo_wr  = (state_q == ST_CAPTURE) && pxl_cen;
    assign fifo_din = {vs, hs, red, green, blue};

    always_ff @(posedge pxl_clk or posedge rst_base) begin
        if (rst_base) begin
            state_q      <= ST_IDLE;
            vs_q         <= 1'b0;
            frame_cnt_q  <= '0;
            cap_frames_q <= '0;
            capturing_q  <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            vs_q <= vs;
            if (vs_rise) frame_cnt_q <= frame_inc;
            if (fifo_drop) overflow_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (cap_start) begin
                        state_q      <= ST_CAPTURE;
                        capturing_q  <= 1'b1;
                        cap_frames_q <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (downloading) begin
                        state_q      <= ST_IDLE;
                        capturing_q  <= 1'b0;
                        cap_frames_q <= '0;
                    end else if (frame_end) begin
                        cap_frames_q <= cap_frames_q + 32'd1;
                        if (FRAMES_U != 32'd0 && cap_frames_q + 32'd1 == FRAMES_U) begin
                            state_q     <= ST_DONE;
                            capturing_q <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
                end
                ST_DONE: state_q <= ST_DONE;
                default: begin
                    state_q     <= ST_IDLE;
                    capturing_q <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    jtframe_vid_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (pxl_clk),
        .rst     (rst_base),
        .wr_i    (fifo_wr),
        .din_i   (fifo_din),
        .rd_i    (vid.dout_ready),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .drop_o  (fifo_drop)
    );

    assign vid.dout       = fifo_dout;
    assign vid.dout_valid = !fifo_empty;
    assign frame_cnt      = frame_cnt_q;
    assign capturing      = capturing_q;
    assign done           = done_q;
    assign overflow       = overflow_q;

`ifdef JTFRAME_VIDCRC_EN
    logic [15:0] crc_run_q, crc_q, crc_next;
    logic        crc_valid_q, fifo_accept;

    assign fifo_accept = fifo_wr && !fifo_drop;

    always_comb begin
        crc_next = crc_run_q;
        if (fifo_accept) crc_next = crc16_step(crc_run_q, 24'({red, green, blue}), 3 * CW);
    end

    always_ff @(posedge pxl_clk or posedge rst_base) begin
        if (rst_base) begin
            crc_run_q   <= CRC_INIT;
            crc_q       <= '0;
            crc_valid_q <= 1'b0;
        end else begin
            crc_valid_q <= 1'b0;
            if (frame_end) begin
                crc_q       <= crc_next;
                crc_valid_q <= 1'b1;
                crc_run_q   <= CRC_INIT;
            end else if (cap_start) begin
                crc_run_q <= CRC_INIT;
            end else begin
                crc_run_q <= crc_next;
            end
        end
    end

    assign crc       = crc_q;
    assign crc_valid = crc_valid_q;
`else
    logic unused_full;
    assign unused_full = fifo_full;
    assign crc         = 16'h0000;
    assign crc_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_jtframe_vid_capture.sv
// tb/tb_jtframe_vid_capture.sv - scoreboard bench for jtframe_vid_capture
module tb_jtframe_vid_capture;
    localparam int CW    = 4;
    localparam int DEPTH = 4;
    localparam int W     = 3 * CW + 2;

    logic          pxl_clk = 1'b0;
    logic          rst_base = 1'b1;
    logic          pxl_cen = 1'b0;
    logic          hs = 1'b0;
    logic          vs = 1'b0;
    logic          downloading = 1'b0;
    logic [CW-1:0] red = '0, green = '0, blue = '0;
    logic [31:0]   frame_cnt;
    logic          capturing, done, overflow, crc_valid;
    logic [15:0]   crc;

    jtframe_vid_capture_if #(.W(W)) vid ();

    jtframe_vid_capture #(
        .CW     (CW),
        .DEPTH  (DEPTH),
        .START  (2),
        .FRAMES (1)
    ) dut (
        .pxl_clk     (pxl_clk),
        .rst_base    (rst_base),
        .pxl_cen     (pxl_cen),
        .hs          (hs),
        .vs          (vs),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .downloading (downloading),
        .frame_cnt   (frame_cnt),
        .vid         (vid),
        .capturing   (capturing),
        .done        (done),
        .overflow    (overflow),
        .crc         (crc),
        .crc_valid   (crc_valid)
    );

    always #5 pxl_clk = ~pxl_clk;

    int           vectors = 0;
    int           errors  = 0;
    int           seq     = 0;
    logic         zero_pix = 1'b0;
    logic [15:0]  crc_model = 16'hFFFF;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;

    function automatic logic [15:0] crc_ref(input logic [15:0] c_in, input logic [3*CW-1:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 3 * CW - 1; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Handshake completes at the next rising edge; sample on the falling edge
    always @(negedge pxl_clk) begin
        if (!rst_base && vid.dout_valid === 1'b1 && vid.dout_ready === 1'b1) begin
            chk("record_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                chk("record", 32'(vid.dout), 32'(mon_exp));
            end
        end
    end

    task automatic tick();
        @(posedge pxl_clk);
        #1;
    endtask

    task automatic vs_pulse();
        pxl_cen = 1'b0;
        vs = 1'b1;
        tick();
        vs = 1'b0;
        tick();
    endtask

    task automatic pix(input int n, input bit push);
        for (int i = 0; i < n; i++) begin
            seq++;
            red   = zero_pix ? '0 : CW'(seq);
            green = zero_pix ? '0 : CW'(seq * 3 + 1);
            blue  = zero_pix ? '0 : CW'(~seq);
            hs    = seq[0];
            pxl_cen = 1'b1;
            if (push) begin
                exp_q.push_back({1'b0, hs, red, green, blue});
                crc_model = crc_ref(crc_model, {red, green, blue});
            end
            tick();
        end
        pxl_cen = 1'b0;
    endtask

    task automatic reset_dut();
        rst_base = 1'b1;
        tick();
        rst_base = 1'b0;
        tick();
    endtask

    task automatic enter_capture();
        vs_pulse();
        vs_pulse();
        crc_model = 16'hFFFF;
    endtask

    // vs edge that closes the single captured frame
    task automatic close_frame(input string tag);
        logic [15:0] exp_crc;
        logic        exp_v;
`ifdef JTFRAME_VIDCRC_EN
        exp_crc = crc_model;
        exp_v   = 1'b1;
`else
        exp_crc = 16'h0000;
        exp_v   = 1'b0;
`endif
        pxl_cen = 1'b0;
        vs = 1'b1;
        tick();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_capturing"}, 32'(capturing), 32'd0);
        chk({tag, "_crc"}, 32'(crc), 32'(exp_crc));
        chk({tag, "_crc_valid"}, 32'(crc_valid), 32'(exp_v));
        vs = 1'b0;
        tick();
        chk({tag, "_crc_valid_pulse"}, 32'(crc_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vid.dout_ready = 1'b0;
        tick();
        tick();
        chk("rst_frame_cnt", frame_cnt, 32'd0);
        chk("rst_dout_valid", 32'(vid.dout_valid), 32'd0);
        chk("rst_dout", 32'(vid.dout), 32'd0);
        chk("rst_capturing", 32'(capturing), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_crc", 32'(crc), 32'd0);
        chk("rst_crc_valid", 32'(crc_valid), 32'd0);
        rst_base = 1'b0;
        tick();

        // START=2, FRAMES=1: only the frame after the second vs pulse is captured
        vid.dout_ready = 1'b1;
        pix(10, 0);
        vs_pulse();
        chk("a_frame_cnt1", frame_cnt, 32'd1);
        chk("a_idle_before_start", 32'(capturing), 32'd0);
        pix(10, 0);
        vs_pulse();
        chk("a_frame_cnt2", frame_cnt, 32'd2);
        chk("a_capturing", 32'(capturing), 32'd1);
        crc_model = 16'hFFFF;
        pix(10, 1);
        close_frame("a");
        chk("a_frame_cnt3", frame_cnt, 32'd3);
        pix(10, 0);
        repeat (4) tick();
        chk("a_all_drained", 32'(exp_q.size()), 32'd0);
        chk("a_no_writes_in_done", 32'(vid.dout_valid), 32'd0);
        chk("a_done_terminal", 32'(done), 32'd1);

        // Fill to DEPTH, read+write while full, then overflow
        reset_dut();
        enter_capture();
        vid.dout_ready = 1'b0;
        pix(4, 1);
        chk("b_full_valid", 32'(vid.dout_valid), 32'd1);
        chk("b_no_overflow_at_full", 32'(overflow), 32'd0);
        vid.dout_ready = 1'b1;
        pix(1, 1);
        vid.dout_ready = 1'b0;
        chk("b_rw_full_no_overflow", 32'(overflow), 32'd0);
        pix(2, 0);
        chk("b_overflow", 32'(overflow), 32'd1);
        vid.dout_ready = 1'b1;
        repeat (6) tick();
        chk("b_drained", 32'(exp_q.size()), 32'd0);
        chk("b_empty", 32'(vid.dout_valid), 32'd0);
        chk("b_overflow_sticky", 32'(overflow), 32'd1);

        // Download aborts capture; buffered records still come out
        reset_dut();
        enter_capture();
        vid.dout_ready = 1'b0;
        pix(3, 1);
        downloading = 1'b1;
        tick();
        chk("c_capturing_off", 32'(capturing), 32'd0);
        pix(2, 0);
        downloading = 1'b0;
        vid.dout_ready = 1'b1;
        repeat (6) tick();
        chk("c_drained", 32'(exp_q.size()), 32'd0);
        chk("c_empty", 32'(vid.dout_valid), 32'd0);

        // Asynchronous reset mid-capture
        reset_dut();
        enter_capture();
        vid.dout_ready = 1'b0;
        pix(3, 0);
        chk("d_buffered", 32'(vid.dout_valid), 32'd1);
        rst_base = 1'b1;
        #1;
        chk("d_async_valid", 32'(vid.dout_valid), 32'd0);
        chk("d_async_frame_cnt", frame_cnt, 32'd0);
        chk("d_async_capturing", 32'(capturing), 32'd0);
        chk("d_async_dout", 32'(vid.dout), 32'd0);
        tick();
        rst_base = 1'b0;
        tick();

        // Single black pixel frame for the checksum
        enter_capture();
        vid.dout_ready = 1'b1;
        zero_pix = 1'b1;
        pix(1, 1);
        zero_pix = 1'b0;
        tick();
        close_frame("e");
        repeat (2) tick();
        chk("e_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
